issue_commit_mpu: RTL and testbench

//  Multi-port issue/commit tracker between MPU dispatch and the TPU array.

---
 rtl/issue_commit_mpu_pkg.sv | 20 ++
 rtl/issue_commit_mpu_commit_decode.sv | 46 ++++
 rtl/issue_commit_mpu.sv | 144 ++++++++++++++
 tb/tb_issue_commit_mpu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_commit_mpu_pkg.sv
// Shared types and default sizing for the MPU issue/commit tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkg_mpu;

    localparam int DEF_NUM_ISSUE        = 16;
    localparam int DEF_NUM_COMMIT_PORTS = 2;
    localparam int DEF_WIDTH_THREADID   = 8;
    localparam int DEF_WIDTH_ISSUE      = $clog2(DEF_NUM_ISSUE);

    typedef logic [DEF_WIDTH_ISSUE-1:0] mpu_issue_no_t;

    // One tracking-table slot: occupied, committed, and the owning thread.
    typedef struct packed {
        logic                          valid;
        logic                          done;
        logic [DEF_WIDTH_THREADID-1:0] threadid;
    } commit_ent_t;

endpackage

// File: rtl/issue_commit_mpu_commit_decode.sv
// Turns the per-port commit numbers into a table set-mask plus an illegal-commit flag.
// Latency: purely combinational.
// Backpressure: none; every commit port is accepted (illegal ones masked when MPU_COMMIT_CHECK_EN).
module commit_decode_mpu
    import pkg_mpu::*;
#(
    parameter int NUM_ISSUE        = DEF_NUM_ISSUE,
    parameter int NUM_COMMIT_PORTS = DEF_NUM_COMMIT_PORTS,
    parameter int WIDTH_ISSUE      = $clog2(NUM_ISSUE)
) (
    input  logic [NUM_COMMIT_PORTS-1:0]             req_commit,
    input  logic [NUM_COMMIT_PORTS*WIDTH_ISSUE-1:0] commit_no,
    input  logic [NUM_ISSUE-1:0]                    ent_valid,
    input  logic [NUM_ISSUE-1:0]                    ent_done,
    output logic [NUM_ISSUE-1:0]                    set_mask,
    output logic                                    illegal
);

    // Legality is judged against the registered table, so two ports naming
    // the same live entry in one cycle both see done=0 and neither is flagged.
    always_comb begin
        set_mask = '0;
        illegal  = 1'b0;
        for (int p = 0; p < NUM_COMMIT_PORTS; p++) begin
            if (req_commit[p]) begin
`ifdef MPU_COMMIT_CHECK_EN
                if (ent_valid[commit_no[p*WIDTH_ISSUE +: WIDTH_ISSUE]] &&
                    !ent_done[commit_no[p*WIDTH_ISSUE +: WIDTH_ISSUE]]) begin
                    set_mask[commit_no[p*WIDTH_ISSUE +: WIDTH_ISSUE]] = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
`else
                set_mask[commit_no[p*WIDTH_ISSUE +: WIDTH_ISSUE]] = 1'b1;
`endif
            end
        end
    end

`ifndef MPU_COMMIT_CHECK_EN
    // Table state is only consulted when checking is built in.
    logic unused_ent;
    assign unused_ent = ^{ent_valid, ent_done};
`endif

endmodule

// File: rtl/issue_commit_mpu.sv
// In-order retire tracker: issues numbers from a circular table, takes out-of-order commits, retires in order.
// Latency: issue ack is combinational; commit at edge t retires at edge t+1 if the entry is head.
// Backpressure: issue refused while full (a same-cycle retire frees the slot only next cycle). Build option MPU_COMMIT_CHECK_EN.
module issue_commit_mpu
    import pkg_mpu::*;
#(
    parameter int NUM_ISSUE        = DEF_NUM_ISSUE,
    parameter int WIDTH_ISSUE      = $clog2(NUM_ISSUE),
    parameter int NUM_COMMIT_PORTS = DEF_NUM_COMMIT_PORTS,
    parameter int WIDTH_THREADID   = DEF_WIDTH_THREADID
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    I_Req_Issue,
    input  logic [WIDTH_THREADID-1:0]               I_ThreadID,
    output logic                                    O_Ack_Issue,
    output logic [WIDTH_ISSUE-1:0]                  O_IssueNo,
    input  logic [NUM_COMMIT_PORTS-1:0]             I_Req_Commit,
    input  logic [NUM_COMMIT_PORTS*WIDTH_ISSUE-1:0] I_CommitNo,
    output logic                                    O_Req_Retire,
    output logic [WIDTH_ISSUE-1:0]                  O_Retire_No,
    output logic [WIDTH_THREADID-1:0]               O_Retire_ThreadID,
    output logic                                    O_Full,
    output logic                                    O_Empty,
    output logic [WIDTH_ISSUE:0]                    O_Count,
    output logic                                    O_Err_Commit
);

    localparam int              PW       = WIDTH_ISSUE + 1;
    localparam logic [PW-1:0]   FULL_CNT = PW'(NUM_ISSUE);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    // Table entries use the package layout, so WIDTH_THREADID must match it.
    commit_ent_t                   tbl_q [NUM_ISSUE];
    commit_ent_t                   tbl_d [NUM_ISSUE];
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic                          retire_vld_q, retire_vld_d;
    logic [WIDTH_ISSUE-1:0]        retire_no_q, retire_no_d;
    logic [WIDTH_THREADID-1:0]     retire_tid_q, retire_tid_d;
    logic                          err_q, err_d;

    logic [PW-1:0]                 count;
    logic                          full;
    logic [NUM_ISSUE-1:0]          ent_valid, ent_done, set_mask;
    logic                          illegal;
    logic [WIDTH_ISSUE-1:0]        rd_idx, wr_idx;
    commit_ent_t                   head;

    commit_decode_mpu #(
        .NUM_ISSUE        (NUM_ISSUE),
        .NUM_COMMIT_PORTS (NUM_COMMIT_PORTS),
        .WIDTH_ISSUE      (WIDTH_ISSUE)
    ) u_decode (
        .req_commit (I_Req_Commit),
        .commit_no  (I_CommitNo),
        .ent_valid  (ent_valid),
        .ent_done   (ent_done),
        .set_mask   (set_mask),
        .illegal    (illegal)
    );

    // Occupancy and issue handshake come from registered pointers only.
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        full        = (count == FULL_CNT);
        rd_idx      = rd_ptr_q[WIDTH_ISSUE-1:0];
        wr_idx      = wr_ptr_q[WIDTH_ISSUE-1:0];
        head        = tbl_q[rd_idx];
        O_Count     = count;
        O_Full      = full;
        O_Empty     = (count == '0);
        O_Ack_Issue = I_Req_Issue & ~full;
        O_IssueNo   = wr_idx;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            ent_valid[i] = tbl_q[i].valid;
            ent_done[i]  = tbl_q[i].done;
        end
    end

    // Next table/pointer state: commits set done, retire frees the head, issue fills the tail.
    always_comb begin
        tbl_d        = tbl_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        retire_vld_d = 1'b0;
        retire_no_d  = retire_no_q;
        retire_tid_d = retire_tid_q;
        err_d        = illegal;

        for (int i = 0; i < NUM_ISSUE; i++) begin
            if (set_mask[i]) begin
                tbl_d[i].done = 1'b1;
            end
        end

        // Retire clears after the commit set so a freed head never stays done.
        if (head.valid && head.done) begin
            tbl_d[rd_idx].valid = 1'b0;
            tbl_d[rd_idx].done  = 1'b0;
            rd_ptr_d            = rd_ptr_q + PTR_ONE;
            retire_vld_d        = 1'b1;
            retire_no_d         = rd_idx;
            retire_tid_d        = head.threadid;
        end

        // The tail can only alias the head when full, and full blocks issue.
        if (O_Ack_Issue) begin
            tbl_d[wr_idx].valid    = 1'b1;
            tbl_d[wr_idx].done     = 1'b0;
            tbl_d[wr_idx].threadid = I_ThreadID;
            wr_ptr_d               = wr_ptr_q + PTR_ONE;
        end
    end

    // State registers; reset discards every outstanding entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ISSUE; i++) begin
                tbl_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            retire_vld_q <= 1'b0;
            retire_no_q  <= '0;
            retire_tid_q <= '0;
            err_q        <= 1'b0;
        end else begin
            tbl_q        <= tbl_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            retire_vld_q <= retire_vld_d;
            retire_no_q  <= retire_no_d;
            retire_tid_q <= retire_tid_d;
            err_q        <= err_d;
        end
    end

    assign O_Req_Retire      = retire_vld_q;
    assign O_Retire_No       = retire_no_q;
    assign O_Retire_ThreadID = retire_tid_q;
    assign O_Err_Commit      = err_q;

endmodule

// File: tb/tb_issue_commit_mpu.sv
// Bench for issue_commit_mpu: directed issue/commit sequences, retires checked by a scoreboard.
// Latency: retire expected one edge after the commit that completes the head.
// Backpressure: exercises the full-table refusal and wrap-around reissue.
module tb_issue_commit_mpu;
    import pkg_mpu::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Req_Issue;
    logic [7:0]  I_ThreadID;
    logic        O_Ack_Issue;
    logic [3:0]  O_IssueNo;
    logic [1:0]  I_Req_Commit;
    logic [7:0]  I_CommitNo;
    logic        O_Req_Retire;
    logic [3:0]  O_Retire_No;
    logic [7:0]  O_Retire_ThreadID;
    logic        O_Full;
    logic        O_Empty;
    logic [4:0]  O_Count;
    logic        O_Err_Commit;

    typedef struct {
        mpu_issue_no_t no;
        logic [7:0]    tid;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef MPU_COMMIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    issue_commit_mpu dut (
        .clock             (clock),
        .reset             (reset),
        .I_Req_Issue       (I_Req_Issue),
        .I_ThreadID        (I_ThreadID),
        .O_Ack_Issue       (O_Ack_Issue),
        .O_IssueNo         (O_IssueNo),
        .I_Req_Commit      (I_Req_Commit),
        .I_CommitNo        (I_CommitNo),
        .O_Req_Retire      (O_Req_Retire),
        .O_Retire_No       (O_Retire_No),
        .O_Retire_ThreadID (O_Retire_ThreadID),
        .O_Full            (O_Full),
        .O_Empty           (O_Empty),
        .O_Count           (O_Count),
        .O_Err_Commit      (O_Err_Commit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [7:0] tid, input logic [3:0] exp_no, input logic exp_ack);
        I_Req_Issue = 1'b1;
        I_ThreadID  = tid;
        #1;
        chk("issue_ack", O_Ack_Issue, exp_ack);
        if (exp_ack) chk("issue_no", O_IssueNo, exp_no);
        cyc();
        I_Req_Issue = 1'b0;
    endtask

    task automatic do_commit(input logic [1:0] req, input logic [3:0] no0, input logic [3:0] no1);
        I_Req_Commit = req;
        I_CommitNo   = {no1, no0};
        cyc();
        I_Req_Commit = 2'b00;
    endtask

    task automatic push(input logic [3:0] no, input logic [7:0] tid);
        exp_t e;
        e.no  = no;
        e.tid = tid;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_empty", O_Empty, 1);
        chk("rst_full", O_Full, 0);
        chk("rst_count", O_Count, 0);
        chk("rst_retire", O_Req_Retire, 0);
        chk("rst_retire_no", O_Retire_No, 0);
        chk("rst_retire_tid", O_Retire_ThreadID, 0);
        chk("rst_err", O_Err_Commit, 0);
    endtask

    // Scoreboard monitor: every retire pulse must match the next expected entry.
    always @(negedge clock) begin
        if (!reset && O_Req_Retire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: retire no %0h tid %0h with nothing expected", O_Retire_No, O_Retire_ThreadID);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (O_Retire_No !== e.no || O_Retire_ThreadID !== e.tid) begin
                    errors++;
                    $display("FAIL sb_retire: got no %0h tid %0h expected no %0h tid %0h",
                             O_Retire_No, O_Retire_ThreadID, e.no, e.tid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        I_Req_Issue  = 1'b0;
        I_ThreadID   = '0;
        I_Req_Commit = '0;
        I_CommitNo   = '0;
        repeat (2) cyc();
        chk_reset_vals();
        reset = 1'b0;
        cyc();
        chk_reset_vals();

        // First issue and out-of-order commit/retire
        do_issue(8'h11, 4'd0, 1'b1);
        chk("count_after_first", O_Count, 1);
        chk("empty_after_first", O_Empty, 0);
        do_issue(8'h22, 4'd1, 1'b1);
        do_issue(8'h33, 4'd2, 1'b1);
        chk("count_three", O_Count, 3);
        do_commit(2'b01, 4'd2, 4'd0);
        cyc();
        chk("no_retire_tail_commit", O_Req_Retire, 0);
        do_commit(2'b10, 4'd0, 4'd1);
        cyc();
        chk("no_retire_mid_commit", O_Req_Retire, 0);
        push(4'd0, 8'h11);
        push(4'd1, 8'h22);
        push(4'd2, 8'h33);
        do_commit(2'b01, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("retire_consecutive", O_Req_Retire, 1);
        end
        cyc();
        chk("retire_stops", O_Req_Retire, 0);
        chk("count_drained", O_Count, 0);
        chk("empty_drained", O_Empty, 1);

        // Reset with four entries outstanding
        for (int i = 0; i < 4; i++) begin
            do_issue(8'h50 + 8'(i), 4'(3 + i), 1'b1);
        end
        chk("count_four", O_Count, 4);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        cyc();
        reset = 1'b0;

        // Fill the table, refusal when full, wrap-around reissue
        do_issue(8'h40, 4'd0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            do_issue(8'h40 + 8'(i), 4'(i), 1'b1);
        end
        chk("full_set", O_Full, 1);
        chk("count_full", O_Count, 16);
        do_issue(8'hEE, 4'd0, 1'b0);
        chk("count_refused", O_Count, 16);
        push(4'd0, 8'h40);
        do_commit(2'b01, 4'd0, 4'd0);
        do_issue(8'hEF, 4'd0, 1'b0);
        chk("retire_while_full", O_Req_Retire, 1);
        chk("count_after_retire", O_Count, 15);
        chk("full_cleared", O_Full, 0);
        do_issue(8'hA0, 4'd0, 1'b1);
        chk("count_refilled", O_Count, 16);
        chk("full_again", O_Full, 1);

        // Drain 1..4 on both ports, then duplicate commit plus issue in one cycle
        push(4'd1, 8'h41);
        push(4'd2, 8'h42);
        do_commit(2'b11, 4'd1, 4'd2);
        push(4'd3, 8'h43);
        push(4'd4, 8'h44);
        do_commit(2'b11, 4'd3, 4'd4);
        repeat (3) cyc();
        chk("count_twelve", O_Count, 12);
        push(4'd5, 8'h45);
        I_Req_Commit = 2'b11;
        I_CommitNo   = {4'd5, 4'd5};
        I_Req_Issue  = 1'b1;
        I_ThreadID   = 8'h99;
        #1;
        chk("simul_ack", O_Ack_Issue, 1);
        chk("simul_issue_no", O_IssueNo, 1);
        cyc();
        I_Req_Commit = 2'b00;
        I_Req_Issue  = 1'b0;
        chk("simul_count", O_Count, 13);
        chk("dup_no_err", O_Err_Commit, 0);
        cyc();
        chk("simul_retire", O_Req_Retire, 1);
        chk("simul_count_after", O_Count, 12);
        chk("dup_no_err_late", O_Err_Commit, 0);
        cyc();
        chk("single_retire", O_Req_Retire, 0);

        // Commit into an empty table
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_commit(2'b01, 4'd7, 4'd0);
        chk("err_pulse", O_Err_Commit, EXP_ERR);
        chk("err_no_retire", O_Req_Retire, 0);
        cyc();
        chk("err_one_cycle", O_Err_Commit, 0);
        chk("err_count", O_Count, 0);
        chk("err_no_retire_late", O_Req_Retire, 0);

        repeat (3) cyc();
        chk("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
